// File: rtl/pn_priority_ctrl.sv
// Priority sequencer for the 2-stage, 4-port deflection network: golden-packet
// epoch rotation, LFSR tie-break bits and round-robin silver port selection.
module pn_priority_ctrl #(
   parameter int          NUM_NODES = 16,
   parameter int          NUM_MSHR  = 8,
   parameter int          EPOCH_LEN = 64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         RID_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
   localparam int         MID_W     = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1,
   localparam int         CNT_W     = $clog2(EPOCH_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       in_vld,
   output logic [RID_W-1:0] golden_req_id,
   output logic [MID_W-1:0] golden_mshr_id,
   output logic             epoch_start,
   output logic [1:0]       rand_num,
   output logic             silver_vld,
   output logic [1:0]       silver_sel
);

   logic [CNT_W-1:0] r_epoch_cnt;
   logic [15:0]      r_lfsr;
   logic [1:0]       r_rr_ptr;

   logic [15:0]      w_lfsr_next;
   logic [1:0]       w_sel;
   logic             w_epoch_end;
   logic             w_mshr_last;
   logic             w_req_last;

   assign w_epoch_end = (r_epoch_cnt == CNT_W'(EPOCH_LEN - 1));
   assign w_mshr_last = (golden_mshr_id == MID_W'(NUM_MSHR - 1));
   assign w_req_last  = (golden_req_id == RID_W'(NUM_NODES - 1));

   always_comb begin
      w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Walk from the farthest offset down so the port nearest r_rr_ptr wins.
   always_comb begin
      w_sel = r_rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (in_vld[r_rr_ptr + 2'(k)]) begin
            w_sel = r_rr_ptr + 2'(k);
         end
      end
   end

   // silver_vld qualifies silver_sel for the cycle it is high; there is no
   // back-pressure, the tagging stage consumes a grant in the cycle it appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_epoch_cnt    <= '0;
         golden_req_id  <= '0;
         golden_mshr_id <= '0;
         epoch_start    <= 1'b0;
         r_lfsr         <= LFSR_SEED;
         rand_num       <= LFSR_SEED[1:0];
         r_rr_ptr       <= 2'd0;
         silver_vld     <= 1'b0;
         silver_sel     <= 2'd0;
      end else if (en) begin
         r_lfsr   <= w_lfsr_next;
         rand_num <= w_lfsr_next[1:0];

         if (w_epoch_end) begin
            r_epoch_cnt <= '0;
            epoch_start <= 1'b1;
            if (w_mshr_last) begin
               golden_mshr_id <= '0;
               golden_req_id  <= w_req_last ? '0 : golden_req_id + 1'b1;
            end else begin
               golden_mshr_id <= golden_mshr_id + 1'b1;
            end
         end else begin
            r_epoch_cnt <= r_epoch_cnt + 1'b1;
            epoch_start <= 1'b0;
         end

         if (|in_vld) begin
            silver_vld <= 1'b1;
            silver_sel <= w_sel;
            r_rr_ptr   <= w_sel + 2'd1;
         end else begin
            silver_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pn_priority_ctrl.sv
// Scoreboard bench for pn_priority_ctrl: a default-size instance and a small
// instance (3 nodes, 2 MSHRs, epoch 3) share stimulus and an abstract model.
module tb_pn_priority_ctrl;

   localparam int S_NODES = 3;
   localparam int S_MSHR  = 2;
   localparam int S_LEN   = 3;
   localparam int W       = 17;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [3:0] in_vld = 4'b0000;

   logic [3:0] b_req;
   logic [2:0] b_mshr;
   logic       b_es;
   logic [1:0] b_rand;
   logic       b_svld;
   logic [1:0] b_ssel;

   logic [1:0] s_req;
   logic [0:0] s_mshr;
   logic       s_es;
   logic [1:0] s_rand;
   logic       s_svld;
   logic [1:0] s_ssel;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];

   // model state: enabled-cycle count since reset, LFSR, RR pointer, last grant
   int          m_t;
   logic [15:0] m_lfsr;
   int          m_ptr;
   logic        m_svld;
   int          m_ssel;

   pn_priority_ctrl u_big (
      .clk(clk), .reset(reset), .en(en), .in_vld(in_vld),
      .golden_req_id(b_req), .golden_mshr_id(b_mshr), .epoch_start(b_es),
      .rand_num(b_rand), .silver_vld(b_svld), .silver_sel(b_ssel)
   );

   pn_priority_ctrl #(.NUM_NODES(S_NODES), .NUM_MSHR(S_MSHR), .EPOCH_LEN(S_LEN)) u_small (
      .clk(clk), .reset(reset), .en(en), .in_vld(in_vld),
      .golden_req_id(s_req), .golden_mshr_id(s_mshr), .epoch_start(s_es),
      .rand_num(s_rand), .silver_vld(s_svld), .silver_sel(s_ssel)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // golden identity from the epoch index: epoch e owns flat id e mod (nodes*mshr)
   task automatic golden(input int t, input int len, input int nodes, input int mshr,
                         output int req, output int mid, output int es);
      int flat;
      flat = (t / len) % (nodes * mshr);
      req  = flat / mshr;
      mid  = flat % mshr;
      es   = (t != 0 && (t % len) == 0) ? 1 : 0;
   endtask

   task automatic model_step(input logic rst_i, input logic en_i, input logic [3:0] v);
      int br, bm, be, sr, sm, se;
      logic found;
      if (rst_i) begin
         m_t = 0; m_lfsr = 16'hACE1; m_ptr = 0; m_svld = 1'b0; m_ssel = 0;
      end else if (en_i) begin
         m_t++;
         m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
         if (v != 4'b0000) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (!found && v[(m_ptr + k) % 4]) begin
                  found  = 1'b1;
                  m_ssel = (m_ptr + k) % 4;
               end
            end
            m_ptr  = (m_ssel + 1) % 4;
            m_svld = 1'b1;
         end else begin
            m_svld = 1'b0;
         end
      end
      golden(m_t, 64, 16, 8, br, bm, be);
      golden(m_t, S_LEN, S_NODES, S_MSHR, sr, sm, se);
      exp_q.push_back({4'(br), 3'(bm), 1'(be), 2'(sr), 1'(sm), 1'(se),
                       m_lfsr[1:0], m_svld, 2'(m_ssel)});
   endtask

   // driver
   task automatic drive(input logic rst_i, input logic en_i, input logic [3:0] v);
      @(negedge clk);
      reset  = rst_i;
      en     = en_i;
      in_vld = v;
      model_step(rst_i, en_i, v);
   endtask

   // monitor: outputs are presented every cycle, one expectation per driven edge
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("big_req",    int'(b_req),  int'(e[16:13]));
            chk("big_mshr",   int'(b_mshr), int'(e[12:10]));
            chk("big_es",     int'(b_es),   int'(e[9]));
            chk("small_req",  int'(s_req),  int'(e[8:7]));
            chk("small_mshr", int'(s_mshr), int'(e[6]));
            chk("small_es",   int'(s_es),   int'(e[5]));
            chk("rand",       int'(b_rand), int'(e[4:3]));
            chk("small_rand", int'(s_rand), int'(e[4:3]));
            chk("svld",       int'(b_svld), int'(e[2]));
            chk("small_svld", int'(s_svld), int'(e[2]));
            if (e[2]) begin
               chk("ssel",       int'(b_ssel), int'(e[1:0]));
               chk("small_ssel", int'(s_ssel), int'(e[1:0]));
            end
         end
      end
   end

   initial begin
      int guard;
      // reset, then two enabled idle cycles (rand 00, 00)
      drive(1'b1, 1'b0, 4'b0000);
      drive(1'b1, 1'b1, 4'b1111);
      drive(1'b0, 1'b1, 4'b0000);
      drive(1'b0, 1'b1, 4'b0000);
      // all ports valid: 0,1,2,3,0
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 4'b1111);
      // from reset, 1010 then idle then 0100
      drive(1'b1, 1'b1, 4'b0000);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'b1010);
      drive(1'b0, 1'b1, 4'b0000);
      drive(1'b0, 1'b1, 4'b0100);
      // random traffic with enable always high
      for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      // freeze while a small-epoch pulse is showing
      guard = 0;
      while ((m_t % S_LEN) != 0 && guard < 20) begin
         drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
         guard++;
      end
      chk("reach_pulse", (m_t % S_LEN), 0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      // advance to count 2 of the small epoch, then reset
      drive(1'b0, 1'b1, 4'b0011);
      drive(1'b0, 1'b1, 4'b1100);
      drive(1'b1, 1'b1, 4'b1111);
      drive(1'b0, 1'b0, 4'b0000);
      // long run so the default instance wraps its full golden space
      for (int i = 0; i < 9000; i++)
         drive(1'b0, ($urandom_range(0, 19) != 0), 4'($urandom_range(0, 15)));
      // mixed run with occasional reset
      for (int i = 0; i < 1500; i++)
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)));
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      chk("queue_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
